// File: rtl/leaf_mem_rd_arbiter.sv
// Round-robin burst arbiter for the leaf SRAM read port; beat 0 issues in the grant cycle.
// Responses return READ_LATENCY cycles after each csb0-low cycle; requests wait (held valid) while a burst runs.
module leaf_mem_rd_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int NUM_LEAVES   = 64,
  parameter int ADDR_WIDTH   = $clog2(NUM_LEAVES),
  parameter int MAX_BURST    = 64,
  parameter int LEN_WIDTH    = $clog2(MAX_BURST + 1),
  parameter int READ_LATENCY = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]     req_len,
  output logic [NUM_REQ-1:0]                    req_grant,
  input  logic                                  arb_flush,
  output logic                                  leaf_mem_csb0,
  output logic                                  leaf_mem_web0,
  output logic [ADDR_WIDTH-1:0]                 leaf_mem_addr0,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic                                  rsp_last,
  output logic                                  busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                                  r_state;
  logic [PTR_W-1:0]                        r_rr;
  logic [PTR_W-1:0]                        r_owner;
  logic [ADDR_WIDTH-1:0]                   r_base;
  logic [LEN_WIDTH-1:0]                    r_len;
  logic [LEN_WIDTH-1:0]                    r_beat;
  logic [READ_LATENCY-1:0]                 r_pv;
  logic [READ_LATENCY-1:0]                 r_pl;
  logic [READ_LATENCY-1:0][PTR_W-1:0]      r_po;

  logic                  w_found;
  logic [PTR_W-1:0]      w_idx;
  logic [PTR_W-1:0]      w_pick;
  logic [PTR_W-1:0]      w_rr_next;
  logic [LEN_WIDTH-1:0]  w_raw_len;
  logic [LEN_WIDTH-1:0]  w_eff_len;
  logic                  w_grant_en;
  logic                  w_burst_en;
  logic                  w_issue;
  logic                  w_issue_last;
  logic [PTR_W-1:0]      w_issue_owner;
  logic [ADDR_WIDTH-1:0] w_burst_addr;
  logic [ADDR_WIDTH-1:0] w_issue_addr;

  // First valid requester at or after the RR pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = PTR_W'((int'(r_rr) + i) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_raw_len = req_len[w_pick];
    if (w_raw_len == '0)
      w_eff_len = LEN_WIDTH'(1);
    else if (w_raw_len > LEN_WIDTH'(MAX_BURST))
      w_eff_len = LEN_WIDTH'(MAX_BURST);
    else
      w_eff_len = w_raw_len;
  end

  assign w_rr_next     = (w_pick == PTR_W'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
  assign w_grant_en    = !rst && !arb_flush && (r_state == S_IDLE) && w_found;
  assign w_burst_en    = !rst && !arb_flush && (r_state == S_BURST);
  assign w_issue       = w_grant_en | w_burst_en;
  assign w_burst_addr  = r_base + ADDR_WIDTH'(r_beat);
  assign w_issue_addr  = w_grant_en ? req_addr[w_pick] : w_burst_addr;
  assign w_issue_owner = w_grant_en ? w_pick : r_owner;
  assign w_issue_last  = w_grant_en ? (w_eff_len == LEN_WIDTH'(1))
                                    : (r_beat == r_len - LEN_WIDTH'(1));

  always_comb begin
    req_grant = '0;
    if (w_grant_en)
      req_grant[w_pick] = 1'b1;
  end

  assign leaf_mem_csb0  = ~w_issue;
  assign leaf_mem_web0  = 1'b1;
  assign leaf_mem_addr0 = w_issue ? w_issue_addr : '0;

  always_comb begin
    rsp_valid = '0;
    if (r_pv[READ_LATENCY-1])
      rsp_valid[r_po[READ_LATENCY-1]] = 1'b1;
  end

  assign rsp_last = r_pv[READ_LATENCY-1] & r_pl[READ_LATENCY-1];
  assign busy     = (r_state == S_BURST) | (|r_pv) | w_grant_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_owner <= '0;
      r_base  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
    end else if (arb_flush) begin
      r_state <= S_IDLE;
    end else if (w_grant_en) begin
      r_rr    <= w_rr_next;
      r_owner <= w_pick;
      r_base  <= req_addr[w_pick];
      r_len   <= w_eff_len;
      r_beat  <= LEN_WIDTH'(1);
      r_state <= (w_eff_len == LEN_WIDTH'(1)) ? S_IDLE : S_BURST;
    end else if (w_burst_en) begin
      r_beat <= r_beat + LEN_WIDTH'(1);
      if (w_issue_last)
        r_state <= S_IDLE;
    end
  end

  // Response shift pipeline: one stage per cycle of SRAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      r_pl <= '0;
      r_po <= '0;
    end else if (arb_flush) begin
      r_pv <= '0;
      r_pl <= '0;
      r_po <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
        r_po[i] <= r_po[i-1];
      end
      r_pv[0] <= w_issue;
      r_pl[0] <= w_issue_last;
      r_po[0] <= w_issue_owner;
    end
  end

endmodule

// File: doc/leaf_mem_rd_arbiter.md
Name: leaf_mem_rd_arbiter

Overview:
- Shares the single leaf-memory read port (port 0) between NUM_REQ requesters, for example the exact-first-row sweep and the per-query search-leaf engine.
- Each requester asks for a burst of consecutive leaf addresses. The arbiter grants round-robin, drives leaf_mem_csb0/web0/addr0 one address per cycle, and routes a tagged read-valid strobe back to the owner after the SRAM read latency.
- Sits between the main controller and the leaf SRAM macro.

Parameters:
- NUM_REQ, 2, number of requesters.
- NUM_LEAVES, 64, leaf memory depth.
- ADDR_WIDTH, $clog2(NUM_LEAVES), leaf address width.
- MAX_BURST, 64, maximum beats per burst.
- LEN_WIDTH, $clog2(MAX_BURST+1), burst length field width.
- READ_LATENCY, 1, cycles from csb0 low to data valid at the SRAM output (must be 1 or more).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  NUM_REQ  per-requester burst request, held until granted.
- req_addr  input  NUM_REQ x ADDR_WIDTH  burst start address.
- req_len  input  NUM_REQ x LEN_WIDTH  beat count, 1..MAX_BURST.
- req_grant  output  NUM_REQ  one-hot, single-cycle pulse that accepts the request.
- arb_flush  input  1  synchronous abort of the current burst and all in-flight responses.
- leaf_mem_csb0  output  1  SRAM chip select, active-low.
- leaf_mem_web0  output  1  SRAM write enable, active-low; tied high (read only).
- leaf_mem_addr0  output  ADDR_WIDTH  SRAM read address.
- rsp_valid  output  NUM_REQ  one-hot, marks the SRAM data as valid for that requester.
- rsp_last  output  1  qualifies the final beat of a burst.
- busy  output  1  high while a burst is issuing or any response is in flight.

Behaviour:
- Reset (rst high, asynchronous):
  - FSM goes to IDLE; RR pointer = 0, so requester 0 has highest priority.
  - Response pipeline is cleared.
  - Outputs: csb0=1, web0=1, addr0=0, req_grant=0, rsp_valid=0, rsp_last=0, busy=0.
  - Reset mid-burst drops all remaining beats and responses; nothing resumes after reset.
- FSM states: IDLE, BURST.
- IDLE:
  - If any req_valid is high, pick the first valid requester at or after the RR pointer, wrapping modulo NUM_REQ.
  - In the same cycle: pulse req_grant[k], issue beat 0 (csb0=0, addr0=req_addr[k]), and latch base address, length and owner k.
  - Set RR pointer = (k+1) mod NUM_REQ.
  - If the effective length is 1, stay in IDLE; otherwise go to BURST.
- BURST:
  - Issue beat n each cycle: csb0=0, addr0=(base+n) mod 2^ADDR_WIDTH. Address wrap is silent.
  - No new grant is issued while in BURST.
  - On the last beat, go to IDLE.
  - The next grant may issue in the cycle immediately after the last beat, so back-to-back bursts have no bubble.
- Length rules:
  - req_len=0 is treated as 1.
  - req_len > MAX_BURST is clamped to MAX_BURST.
- Grant rules:
  - req_grant is combinational from state, req_valid and the RR pointer. It is a pulse.
  - The requester must drop or change req_valid in the cycle after its grant. A still-high req_valid counts as a new request.
- Response path:
  - A shift pipeline of depth READ_LATENCY carries (valid, owner, last) for each issued beat.
  - rsp_valid[owner] and rsp_last appear exactly READ_LATENCY cycles after the corresponding csb0-low cycle.
  - rsp_valid is at most one-hot.
  - rsp_last is high only together with rsp_valid, on the final beat.
- arb_flush (synchronous):
  - In its cycle: no beat issues and no grant is given; csb0=1.
  - FSM goes to IDLE and the pipeline is cleared, so rsp_valid=0 from the next cycle.
  - The RR pointer is unchanged.
  - If arb_flush and req_valid are both high, the flush wins and the request stays pending.
- busy = (state==BURST) OR (any pipeline stage valid) OR (a grant in the current cycle).
- Simultaneous events:
  - A requester lowering req_valid during the other requester's burst has no effect.
  - A request arriving on the final-beat cycle is granted in the next cycle.

Test Plan:
- Req0 addr=10, len=4, READ_LATENCY=1 -> grant0 at t0; csb0 low t0..t3 with addr 10,11,12,13; rsp_valid[0] t1..t4; rsp_last at t4 only; busy low at t5.
- Req0 and req1 both valid continuously with len=2 after reset -> grants in order 0,1,0,1; beats contiguous with no csb0-high bubble; rsp owner tags match the grant order.
- Req1 addr=62, len=4 -> addr0 sequence 62,63,0,1; rsp_last on the 4th response.
- Req0 len=0, then len=100 with MAX_BURST=64 -> one beat, then exactly 64 beats (addr wraps 0..63 from base 0).
- arb_flush asserted on beat 2 of a len=8 burst while req1 is pending -> csb0 high that cycle; no rsp_valid after the flush cycle; req1 granted the following cycle with a full burst.
- rst pulsed mid-burst, asynchronously and between clock edges -> all outputs go to their reset values immediately; after release, a request from 1 with 0 idle gets priority to requester 0 when both are valid.
